sync_fifo_param: RTL and testbench

// - Synchronous single-clock FIFO, parametrised in data width and depth; successor to the fixed 8x8 FIFO.
// - Adds: simultaneous read+write, selectable legacy read-priority mode, occupancy count,

---
 rtl/fifo_pkg.sv | 15 +
 rtl/sync_fifo_param_if.sv | 30 +++
 rtl/fifo_ram.sv | 29 ++
 rtl/sync_fifo_param.sv | 76 +++++++
 tb/tb_sync_fifo_param.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared operation type and pointer-wrap helper for sync_fifo_param.
//   fifo_op_e - accepted operation in a cycle, encoded as {write, read}
//   ptr_inc   - advances a pointer, wrapping depth-1 -> 0 (any depth, not just powers of 2)
package fifo_pkg;
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer bundle for sync_fifo_param.
//   master (user side): drives wen, ren, din, clr_err; observes data, occupancy and status
//   slave  (FIFO side): the mirror image
interface sync_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);
    logic             wen;
    logic             ren;
    logic             clr_err;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic             error;
    logic             overflow;
    logic             underflow;
    modport master (
        output wen, ren, din, clr_err,
        input  dout, count, empty, full, almost_empty, almost_full, error, overflow, underflow
    );
    modport slave (
        input  wen, ren, din, clr_err,
        output dout, count, empty, full, almost_empty, almost_full, error, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM, WIDTH x DEPTH, synchronous write, registered read.
//   clk, rst_n        - clock, synchronous active-low reset (clears rdata only, not the array)
//   we, waddr, wdata  - write port
//   re, raddr, rdata  - read port; rdata updates only when re is high, otherwise holds
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy, thresholds and sticky errors.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - slave side of sync_fifo_param_if (requests, data, count and status flags)
//   RD_PRIORITY=1 reproduces the legacy 8x8 FIFO: a write alongside a read is silently dropped.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int AF_THRESH   = 6,
    parameter int AE_THRESH   = 2,
    parameter int RD_PRIORITY = 0
) (
    input logic              clk,
    input logic              rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam bit RP = RD_PRIORITY != 0;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt_nxt;
    logic          rd_ok, wr_ok, rej_rd, rej_wr;
    fifo_op_e      op;

    // A full FIFO can still take a write when a read frees a slot in the same cycle,
    // unless legacy read priority drops every write that coincides with a read.
    always_comb begin
        rd_ok   = bus.ren && !bus.empty;
        wr_ok   = bus.wen && (RP ? !bus.ren && !bus.full : !bus.full || rd_ok);
        rej_rd  = bus.ren && bus.empty;
        rej_wr  = bus.wen && bus.full && !wr_ok && !(RP && bus.ren);
        op      = fifo_op_e'({wr_ok, rd_ok});
        cnt_nxt = (op == OP_WR) ? bus.count + CW'(1) :
                  (op == OP_RD) ? bus.count - CW'(1) : bus.count;
    end

    // Flags are computed from the next count so they change in the same cycle as count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            bus.count        <= '0;
            bus.empty        <= 1'b1;
            bus.full         <= 1'b0;
            bus.almost_empty <= 1'b1;
            bus.almost_full  <= 1'b0;
            bus.error        <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.underflow    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
            if (rd_ok) rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
            bus.count        <= cnt_nxt;
            bus.empty        <= cnt_nxt == '0;
            bus.full         <= cnt_nxt == CW'(DEPTH);
            bus.almost_empty <= cnt_nxt <= CW'(AE_THRESH);
            bus.almost_full  <= cnt_nxt >= CW'(AF_THRESH);
            bus.error        <= rej_rd || rej_wr;
            bus.underflow    <= rej_rd || (bus.underflow && !bus.clr_err);
            bus.overflow     <= rej_wr || (bus.overflow && !bus.clr_err);
        end
    end

    fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok && rst_n),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (bus.dout)
    );
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives three FIFO configurations from shared stimulus.
//   u0: 8 deep, both-operations mode; u1: 8 deep, legacy read priority; u2: 5 deep (AF=4, AE=1).
//   Expected read data is queued when a read is issued; a monitor pops and compares dout
//   on the cycle after each accepted read. Status outputs are checked inline.
module tb_sync_fifo_param;
    logic       clk = 0, rst_n = 0, wen = 0, ren = 0, clr_err = 0;
    logic [7:0] din = 0;
    int         n_vec = 0, n_err = 0;
    logic [2:0] mon_en = 0, go = 0;
    logic [7:0] q0[$], q1[$], q2[$], mq[$];
    logic [7:0] exp_d;
    logic       rw, rr, rok, wok;
    logic [7:0] rd;
    int         sz, wi, ri;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) b0 ();
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) b1 ();
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(5)) b2 ();

    assign b0.wen = wen;  assign b0.ren = ren;  assign b0.din = din;  assign b0.clr_err = clr_err;
    assign b1.wen = wen;  assign b1.ren = ren;  assign b1.din = din;  assign b1.clr_err = clr_err;
    assign b2.wen = wen;  assign b2.ren = ren;  assign b2.din = din;  assign b2.clr_err = clr_err;

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .RD_PRIORITY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));
    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .RD_PRIORITY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));
    sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .RD_PRIORITY(0)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wen = w;
        ren = r;
        din = d;
        @(negedge clk);
    endtask

    task automatic expect_rd(input logic [7:0] d);
        if (mon_en[0]) q0.push_back(d);
        if (mon_en[1]) q1.push_back(d);
        if (mon_en[2]) q2.push_back(d);
    endtask

    task automatic reset_all();
        rst_n = 0;
        wen = 0;
        ren = 0;
        clr_err = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    // A read is accepted when ren is high on a non-empty FIFO outside reset.
    always @(posedge clk) begin
        go[0] <= mon_en[0] && rst_n && ren && !b0.empty;
        go[1] <= mon_en[1] && rst_n && ren && !b1.empty;
        go[2] <= mon_en[2] && rst_n && ren && !b2.empty;
    end

    always @(negedge clk) begin
        if (go[0]) begin
            if (q0.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL dout0: unexpected read, got 0x%0h", b0.dout);
            end else begin
                exp_d = q0.pop_front();
                chk("dout0", b0.dout, exp_d);
            end
        end
        if (go[1]) begin
            if (q1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL dout1: unexpected read, got 0x%0h", b1.dout);
            end else begin
                exp_d = q1.pop_front();
                chk("dout1", b1.dout, exp_d);
            end
        end
        if (go[2]) begin
            if (q2.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL dout2: unexpected read, got 0x%0h", b2.dout);
            end else begin
                exp_d = q2.pop_front();
                chk("dout2", b2.dout, exp_d);
            end
        end
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        chk("rst count", b0.count, 0);
        chk("rst empty", b0.empty, 1);
        chk("rst full", b0.full, 0);
        chk("rst ae", b0.almost_empty, 1);
        chk("rst af", b0.almost_full, 0);
        chk("rst error", b0.error, 0);
        chk("rst ovf", b0.overflow, 0);
        chk("rst udf", b0.underflow, 0);
        chk("rst dout", b0.dout, 0);

        // underflow and sticky clear
        mon_en = 3'b111;
        step(0, 1, 0);
        chk("udf error", b0.error, 1);
        chk("udf sticky", b0.underflow, 1);
        chk("udf dout", b0.dout, 0);
        chk("udf count", b0.count, 0);
        step(0, 0, 0);
        chk("udf pulse", b0.error, 0);
        chk("udf hold", b0.underflow, 1);
        clr_err = 1;
        step(0, 0, 0);
        clr_err = 0;
        chk("udf clr", b0.underflow, 0);

        // traffic, then reset in the middle of it
        step(1, 0, 8'h11);
        step(1, 0, 8'h22);
        expect_rd(8'h11);
        step(0, 1, 0);
        expect_rd(8'h22);
        step(0, 1, 0);
        step(0, 1, 0);
        chk("dout hold on udf", b0.dout, 8'h22);
        step(1, 0, 8'h33);
        chk("pre-rst udf", b0.underflow, 1);
        chk("pre-rst count", b0.count, 1);
        rst_n = 0; wen = 1; ren = 1; din = 8'h44;
        @(negedge clk);
        rst_n = 1; wen = 0; ren = 0;
        chk("mid rst count", b0.count, 0);
        chk("mid rst empty", b0.empty, 1);
        chk("mid rst dout", b0.dout, 0);
        chk("mid rst error", b0.error, 0);
        chk("mid rst udf", b0.underflow, 0);
        chk("mid rst count5", b2.count, 0);

        // fill and drain, depth 8
        mon_en = 3'b011;
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, 8'(k));
            chk("fill count", b0.count, k);
            chk("fill count rp", b1.count, k);
            chk("fill af", b0.almost_full, k >= 6);
            chk("fill ae", b0.almost_empty, k <= 2);
            chk("fill full", b0.full, k == 8);
        end
        step(1, 0, 8'h09);
        chk("ovf error", b0.error, 1);
        chk("ovf sticky", b0.overflow, 1);
        chk("ovf count", b0.count, 8);
        step(0, 0, 0);
        chk("ovf pulse", b0.error, 0);
        chk("ovf hold", b0.overflow, 1);
        for (int k = 1; k <= 8; k++) begin
            expect_rd(8'(k));
            step(0, 1, 0);
            chk("drain count", b0.count, 8 - k);
            chk("drain ae", b0.almost_empty, (8 - k) <= 2);
            chk("drain empty", b0.empty, k == 8);
        end
        clr_err = 1;
        step(0, 0, 0);
        clr_err = 0;
        chk("ovf clr", b0.overflow, 0);

        // simultaneous read+write on a full FIFO in both modes
        reset_all();
        for (int k = 1; k <= 8; k++) step(1, 0, 8'(k));
        expect_rd(8'h01);
        step(1, 1, 8'hAA);
        chk("rw count", b0.count, 8);
        chk("rw full", b0.full, 1);
        chk("rw error", b0.error, 0);
        chk("rp count", b1.count, 7);
        chk("rp full", b1.full, 0);
        chk("rp error", b1.error, 0);
        chk("rp ovf", b1.overflow, 0);
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 7) ? 8'(i + 2) : 8'hAA;
            q0.push_back(exp_d);
            if (i < 7) q1.push_back(exp_d);
            step(0, 1, 0);
        end
        chk("rw drained", b0.empty, 1);
        chk("rw no udf", b0.underflow, 0);
        chk("rp extra read udf", b1.underflow, 1);

        // wrap with depth 5
        reset_all();
        mon_en = 3'b100;
        wi = 0;
        ri = 0;
        for (int k = 0; k < 5; k++) begin step(1, 0, 8'(32'h20 + wi)); wi++; end
        chk("w5 full", b2.full, 1);
        chk("w5 count", b2.count, 5);
        chk("w5 af", b2.almost_full, 1);
        for (int k = 0; k < 3; k++) begin expect_rd(8'(32'h20 + ri)); ri++; step(0, 1, 0); end
        chk("w5 count2", b2.count, 2);
        chk("w5 ae2", b2.almost_empty, 0);
        for (int k = 0; k < 3; k++) begin step(1, 0, 8'(32'h20 + wi)); wi++; end
        chk("w5 wrap full", b2.full, 1);
        for (int k = 0; k < 5; k++) begin expect_rd(8'(32'h20 + ri)); ri++; step(0, 1, 0); end
        chk("w5 empty", b2.empty, 1);
        for (int k = 0; k < 4; k++) begin step(1, 0, 8'(32'h20 + wi)); wi++; end
        chk("w5 count4", b2.count, 4);
        chk("w5 af4", b2.almost_full, 1);
        chk("w5 full4", b2.full, 0);
        for (int k = 0; k < 4; k++) begin expect_rd(8'(32'h20 + ri)); ri++; step(0, 1, 0); end
        chk("w5 end empty", b2.empty, 1);
        chk("w5 end count", b2.count, 0);

        // random traffic on u0 against a queue model
        reset_all();
        mon_en = 3'b001;
        mq.delete();
        for (int c = 0; c < 1024; c++) begin
            rw = $urandom_range(0, 99) < (c < 512 ? 65 : 35);
            rr = $urandom_range(0, 99) < 50;
            rd = 8'($urandom);
            sz = mq.size();
            rok = rr && sz > 0;
            wok = rw && (sz < 8 || rok);
            if (rok) q0.push_back(mq.pop_front());
            if (wok) mq.push_back(rd);
            step(rw, rr, rd);
            chk("rnd count", b0.count, mq.size());
            chk("rnd empty", b0.empty, mq.size() == 0);
            chk("rnd full", b0.full, mq.size() == 8);
            chk("rnd ae", b0.almost_empty, mq.size() <= 2);
            chk("rnd af", b0.almost_full, mq.size() >= 6);
            chk("rnd error", b0.error, (rr && sz == 0) || (rw && sz == 8 && !wok));
        end
        step(0, 0, 0);
        chk("q0 drained", q0.size(), 0);
        chk("q1 drained", q1.size(), 0);
        chk("q2 drained", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
